// File: rtl/led_serial_drv.sv
// led_serial_drv
// Shifts a WIDTH-bit LED pattern into an external serial LED register.
// Frames start on load_req, on a free-running refresh tick, or from a request
// that arrived while a frame was in progress. The first frame after reset
// starts on its own.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   data     LED pattern, captured only when a frame is accepted
//   load_req single-cycle request for an immediate frame
//   busy     high while a frame is being shifted (LOW/HIGH/FIN)
//   done     one-cycle pulse in the last cycle of a frame
//   led_clk  serial shift clock (LED register samples on its rising edge)
//   led_do   serial data, complemented when INVERT=1
//   led_clr  active-low clear to the LED register
//   led_en   LED register enable
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; led_clk high, led_do holds last bit
// LOW   | led_clk low for DIV cycles; current bit driven on led_do
// HIGH  | led_clk high for DIV cycles; LED register has taken the bit
// FIN   | single cycle with done=1, then back to IDLE

module led_serial_drv #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 2,
  parameter int REFRESH   = 1048576,
  parameter int INVERT    = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load_req,
  output logic             busy,
  output logic             done,
  output logic             led_clk,
  output logic             led_do,
  output logic             led_clr,
  output logic             led_en
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW = $clog2(REFRESH);

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH - 1);
  localparam logic          INV      = (INVERT != 0);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic [RW-1:0]    ref_cnt;
  logic             pending;
  logic             in_rst;
  logic             ref_tick;
  logic             req;

  assign ref_tick = (ref_cnt == REF_LAST);
  assign req      = load_req | ref_tick;

  // Bit that goes out next, and the register contents after it has gone.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      led_clk <= 1'b1;
      led_do  <= INV;
      led_clr <= 1'b0;
      led_en  <= 1'b0;
      ref_cnt <= '0;
      pending <= 1'b0;
      in_rst  <= 1'b1;
      shift_q <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      in_rst  <= 1'b0;
      led_clr <= 1'b1;
      led_en  <= 1'b1;
      done    <= 1'b0;
      ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;

      case (state)
        IDLE: begin
          // The release cycle only arms the automatic first frame; it is
          // then accepted on the following cycle like any pending request.
          if (in_rst) begin
            pending <= 1'b1;
          end else if (req || pending) begin
            state   <= LOW;
            busy    <= 1'b1;
            led_clk <= 1'b0;
            led_do  <= head_bit(data) ^ INV;
            shift_q <= advance(data);
            bit_cnt <= BIT_LAST;
            div_cnt <= DIV_LAST;
            pending <= 1'b0;
          end
        end

        LOW: begin
          if (req) pending <= 1'b1;
          if (div_cnt == '0) begin
            state   <= HIGH;
            led_clk <= 1'b1;
            div_cnt <= DIV_LAST;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end

        HIGH: begin
          if (req) pending <= 1'b1;
          if (div_cnt == '0) begin
            if (bit_cnt != '0) begin
              // led_do only moves here, on entry to LOW.
              state   <= LOW;
              led_clk <= 1'b0;
              led_do  <= head_bit(shift_q) ^ INV;
              shift_q <= advance(shift_q);
              bit_cnt <= bit_cnt - 1'b1;
              div_cnt <= DIV_LAST;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end

        FIN: begin
          if (req) pending <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          led_clk <= 1'b1;
        end
      endcase
    end
  end

endmodule
